boot_loader: RTL and testbench

- Boot sequencer that owns the shared program memory while the core is held in reset.
- Streams a host-supplied program into memory starting at PROG_BASE, reads it back to verify a checksum, then hands the memory bus to the core and releases core reset.
- Sits between the external host/bench stream, the `mem` block and the core's `fetcher`/`decoder`/register reset.

---
 rtl/boot_loader.sv | 169 ++++++++++++++++
 tb/tb_boot_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Boot sequencer: streams a host program into shared memory at PROG_BASE,
// reads it back to confirm the byte checksum, then hands the memory bus to
// the core and releases core reset.
// Optional build macro BOOT_CLEAR_EN: zero the whole program region before loading.
//
// state  | meaning
// IDLE   | loader owns memory, core held in reset, waiting for start
// CLEAR  | writing zeros to PROG_BASE..MEM_DEPTH-1 (BOOT_CLEAR_EN builds only)
// LOAD   | accepting host beats, writing them to memory
// VERIFY | reading the program back and summing it
// RUN    | core owns memory and is out of reset; left only through reset
// ERROR  | overflow or checksum mismatch; start retries the load
module boot_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int PROG_BASE  = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  host_valid,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  host_last,
  output logic                  host_ready,
  output logic                  mem_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  core_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH-1:0] byte_count
);

  localparam int CAP = MEM_DEPTH - PROG_BASE;
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(PROG_BASE);
  localparam logic [ADDR_WIDTH-1:0] CAP_A  = ADDR_WIDTH'(CAP);
  localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
`ifdef BOOT_CLEAR_EN
    S_CLEAR  = 3'd1,
`endif
    S_LOAD   = 3'd2,
    S_VERIFY = 3'd3,
    S_RUN    = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   checksum;
  logic [DATA_WIDTH-1:0]   verify_sum;
  logic [DATA_WIDTH-1:0]   verify_sum_nxt;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic                    beat;

  // Next state plus the memory bus; writes in LOAD must land in the same cycle as the beat.
  always_comb begin
    state_nxt      = state;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    beat           = (state == S_LOAD) && host_valid;
    verify_sum_nxt = verify_sum + mem_rdata;
    case (state)
      S_IDLE, S_ERROR: begin
        if (start) begin
`ifdef BOOT_CLEAR_EN
          state_nxt = S_CLEAR;
`else
          state_nxt = S_LOAD;
`endif
        end
      end
`ifdef BOOT_CLEAR_EN
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = BASE_A + ptr;
        if (ptr == CAP_A - ONE_A) state_nxt = S_LOAD;
      end
`endif
      S_LOAD: begin
        if (beat) begin
          mem_we    = 1'b1;
          mem_addr  = BASE_A + byte_count;
          mem_wdata = host_data;
          if (host_last) state_nxt = S_VERIFY;
          else if (byte_count + ONE_A == CAP_A) state_nxt = S_ERROR;
        end
      end
      S_VERIFY: begin
        mem_addr = BASE_A + ptr;
        // ptr == byte_count is the extra cycle that only captures the final read
        if (ptr == byte_count)
          state_nxt = (verify_sum_nxt == checksum) ? S_RUN : S_ERROR;
      end
      default: ;
    endcase
  end

  // State, datapath registers and state-decoded status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      checksum     <= '0;
      verify_sum   <= '0;
      ptr          <= '0;
      byte_count   <= '0;
      err_code     <= 2'b00;
      host_ready   <= 1'b0;
      mem_sel      <= 1'b1;
      core_reset_n <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nxt;
      host_ready   <= (state_nxt == S_LOAD);
      mem_sel      <= (state_nxt != S_RUN);
      core_reset_n <= (state_nxt == S_RUN);
      done         <= (state_nxt == S_RUN);
      error        <= (state_nxt == S_ERROR);
      busy         <= (state_nxt == S_LOAD) || (state_nxt == S_VERIFY)
`ifdef BOOT_CLEAR_EN
                      || (state_nxt == S_CLEAR)
`endif
                      ;
      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            byte_count <= '0;
            checksum   <= '0;
            err_code   <= 2'b00;
            verify_sum <= '0;
            ptr        <= '0;
          end
        end
`ifdef BOOT_CLEAR_EN
        S_CLEAR: begin
          ptr <= (state_nxt == S_LOAD) ? '0 : ptr + ONE_A;
        end
`endif
        S_LOAD: begin
          if (beat) begin
            byte_count <= byte_count + ONE_A;
            checksum   <= checksum + host_data;
          end
          if (state_nxt == S_VERIFY) begin
            ptr        <= '0;
            verify_sum <= '0;
          end
          if (state_nxt == S_ERROR) err_code <= 2'b01;
        end
        S_VERIFY: begin
          ptr <= ptr + ONE_A;
          if (ptr != '0) verify_sum <= verify_sum_nxt;
          if (state_nxt == S_ERROR) err_code <= 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader with a registered-read memory model.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        host_valid = 1'b0;
  logic [7:0]  host_data = 8'h00;
  logic        host_last = 1'b0;
  logic        host_ready, mem_sel, mem_we, core_reset_n, busy, done, error;
  logic [15:0] mem_addr, byte_count;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [1:0]  err_code;

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  logic corrupt = 1'b0;

  logic [7:0]  mem [0:255];
  logic [7:0]  rdata_q;
  logic [15:0] raddr_q;

  boot_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
    .host_ready(host_ready), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .core_reset_n(core_reset_n), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    rdata_q <= mem[mem_addr[7:0]];
    raddr_q <= mem_addr;
  end
  assign mem_rdata = (corrupt && raddr_q == 16'h0081) ? 8'h00 : rdata_q;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; host_valid = 1'b0; host_last = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1; tick; start = 1'b0;
`ifdef BOOT_CLEAR_EN
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== 16'(32'h80 + i) || mem_wdata !== 8'h00 || host_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL clear_write[%0d]: we=%b addr=%h wdata=%h rdy=%b busy=%b, expected we=1 addr=%h wdata=00 rdy=0 busy=1",
                 i, mem_we, mem_addr, mem_wdata, host_ready, busy, 16'(32'h80 + i));
      end
      tick;
    end
`endif
  endtask

  task automatic send(input logic [7:0] d, input logic last, input int addr_exp);
    host_valid = 1'b1; host_data = d; host_last = last;
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 16'(addr_exp) || mem_wdata !== d || host_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL beat_write: we=%b addr=%h wdata=%h rdy=%b, expected we=1 addr=%h wdata=%h rdy=1",
               mem_we, mem_addr, mem_wdata, host_ready, 16'(addr_exp), d);
    end
    tick;
    host_valid = 1'b0; host_last = 1'b0;
  endtask

  // Idle LOAD cycle; host_last is raised without host_valid and must be ignored.
  task automatic idle_cycle;
    host_valid = 1'b0; host_last = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b0 || host_ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_cycle: we=%b rdy=%b busy=%b, expected we=0 rdy=1 busy=1", mem_we, host_ready, busy);
    end
    tick;
    host_last = 1'b0;
  endtask

  // Counts VERIFY cycles, checking the read address sequence; ends at a negedge.
  task automatic wait_verify(input int n, output int cycles);
    cycles = 0;
    @(negedge clk);
    while (busy === 1'b1 && cycles < 300) begin
      if (cycles < n) begin
        vectors++;
        if (mem_addr !== 16'(32'h80 + cycles) || mem_we !== 1'b0 || host_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL verify_read[%0d]: addr=%h we=%b rdy=%b, expected addr=%h we=0 rdy=0",
                   cycles, mem_addr, mem_we, host_ready, 16'(32'h80 + cycles));
        end
      end
      cycles++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic check_run(input string name, input int n_exp);
    vectors++;
    if ({done, core_reset_n, mem_sel, error, busy} !== 5'b11000 || byte_count !== 16'(n_exp) || err_code !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_run: done=%b crst_n=%b sel=%b err=%b busy=%b cnt=%0d code=%b, expected 1 1 0 0 0 cnt=%0d code=00",
               name, done, core_reset_n, mem_sel, error, busy, byte_count, err_code, n_exp);
    end
  endtask

  task automatic check_reset_values(input string name);
    vectors++;
    if ({host_ready, mem_sel, mem_we, core_reset_n, busy, done, error} !== 7'b0100000 ||
        mem_addr !== 16'h0000 || mem_wdata !== 8'h00 || err_code !== 2'b00 || byte_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL %s: rdy=%b sel=%b we=%b crst_n=%b busy=%b done=%b err=%b addr=%h wdata=%h code=%b cnt=%0d, expected 0 1 0 0 0 0 0 0000 00 00 0",
               name, host_ready, mem_sel, mem_we, core_reset_n, busy, done, error, mem_addr, mem_wdata, err_code, byte_count);
    end
  endtask

  task automatic load_three;
    send(8'hA9, 1'b0, 32'h80);
    send(8'h05, 1'b0, 32'h81);
    send(8'hEA, 1'b1, 32'h82);
  endtask

  task automatic test_reset;
    reset = 1'b1; tick; tick;
    @(negedge clk);
    check_reset_values("reset_values");
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    do_reset;
    do_start;
    load_three;
    wait_verify(3, cyc);
    vectors++;
    if (cyc !== 4) begin miscompares++; $display("FAIL basic_verify_len: got %0d cycles, expected 4", cyc); end
    check_run("basic", 3);
    vectors++;
    if (mem[8'h80] !== 8'hA9 || mem[8'h81] !== 8'h05 || mem[8'h82] !== 8'hEA) begin
      miscompares++;
      $display("FAIL basic_mem: got %h %h %h, expected a9 05 ea", mem[8'h80], mem[8'h81], mem[8'h82]);
    end
    tick;
    start = 1'b1; tick; start = 1'b0;
    @(negedge clk);
    check_run("start_in_run", 3);
    tick;
  endtask

  task automatic test_gaps;
    do_reset;
    do_start;
    send(8'hA9, 1'b0, 32'h80);
    idle_cycle;
    send(8'h05, 1'b0, 32'h81);
    idle_cycle;
    send(8'hEA, 1'b1, 32'h82);
    wait_verify(3, cyc);
    vectors++;
    if (cyc !== 4) begin miscompares++; $display("FAIL gaps_verify_len: got %0d cycles, expected 4", cyc); end
    check_run("gaps", 3);
    tick;
  endtask

  task automatic test_overflow;
    do_reset;
    do_start;
    for (int i = 0; i < 128; i++) send(8'h11, 1'b0, 32'h80 + i);
    @(negedge clk);
    vectors++;
    if ({error, core_reset_n, mem_sel, busy, done, host_ready} !== 6'b101000 || err_code !== 2'b01 || byte_count !== 16'd128) begin
      miscompares++;
      $display("FAIL overflow: err=%b crst_n=%b sel=%b busy=%b done=%b rdy=%b code=%b cnt=%0d, expected 1 0 1 0 0 0 code=01 cnt=128",
               error, core_reset_n, mem_sel, busy, done, host_ready, err_code, byte_count);
    end
    tick;
    do_start;
    @(negedge clk);
    vectors++;
    if (error !== 1'b0 || err_code !== 2'b00 || byte_count !== 16'd0 || host_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_clear: err=%b code=%b cnt=%0d rdy=%b, expected 0 00 0 1", error, err_code, byte_count, host_ready);
    end
    tick;
    load_three;
    wait_verify(3, cyc);
    check_run("reload", 3);
    tick;
  endtask

  task automatic test_checksum;
    do_reset;
    corrupt = 1'b1;
    do_start;
    load_three;
    wait_verify(3, cyc);
    vectors++;
    if (cyc !== 4) begin miscompares++; $display("FAIL cksum_verify_len: got %0d cycles, expected 4", cyc); end
    vectors++;
    if ({error, done, core_reset_n, mem_sel} !== 4'b1001 || err_code !== 2'b10) begin
      miscompares++;
      $display("FAIL cksum_error: err=%b done=%b crst_n=%b sel=%b code=%b, expected 1 0 0 1 code=10",
               error, done, core_reset_n, mem_sel, err_code);
    end
    tick; tick; tick;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || err_code !== 2'b10) begin
      miscompares++;
      $display("FAIL cksum_hold: done=%b code=%b, expected 0 10", done, err_code);
    end
    corrupt = 1'b0;
    tick;
  endtask

  task automatic test_mid_reset;
    do_reset;
    do_start;
    send(8'h3C, 1'b0, 32'h80);
    send(8'h4D, 1'b0, 32'h81);
    reset = 1'b1; tick; reset = 1'b0;
    @(negedge clk);
    check_reset_values("mid_reset_values");
    tick;
    do_start;
    load_three;
    wait_verify(3, cyc);
    check_run("after_mid_reset", 3);
    tick;
  endtask

`ifdef BOOT_CLEAR_EN
  task automatic test_clear;
    do_reset;
    do_start;
    @(negedge clk);
    vectors++;
    if (host_ready !== 1'b1 || busy !== 1'b1 || byte_count !== 16'd0) begin
      miscompares++;
      $display("FAIL clear_to_load: rdy=%b busy=%b cnt=%0d, expected 1 1 0", host_ready, busy, byte_count);
    end
    tick;
    send(8'hEA, 1'b1, 32'h80);
    wait_verify(1, cyc);
    vectors++;
    if (cyc !== 2) begin miscompares++; $display("FAIL clear_verify_len: got %0d cycles, expected 2", cyc); end
    check_run("clear", 1);
    vectors++;
    if (mem[8'h81] !== 8'h00 || mem[8'hFF] !== 8'h00) begin
      miscompares++;
      $display("FAIL clear_mem: got %h %h, expected 00 00", mem[8'h81], mem[8'hFF]);
    end
    tick;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic;
    test_gaps;
    test_overflow;
    test_checksum;
    test_mid_reset;
`ifdef BOOT_CLEAR_EN
    test_clear;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
